// File: rtl/j4io_pkg.sv
// Shared constants for the j4 IO responder: the IO address map, the status-word
// layout and the slot count.
package j4io_pkg;

    localparam int NUM_SLOTS = 4;

    localparam logic [15:0] ADDR_SLOTID = 16'h0001;
    localparam logic [15:0] ADDR_CYCLES = 16'h0002;
    localparam logic [15:0] ADDR_MBOX   = 16'h0010;
    localparam logic [15:0] ADDR_STATUS = 16'h0020;
    localparam logic [15:0] ADDR_KILL   = 16'h0040;

    // Status word bit-field offsets (each field is NUM_SLOTS wide, slot id is 2 bits)
    localparam int ST_EMPTY_LSB = 0;
    localparam int ST_FULL_LSB  = 4;
    localparam int ST_OVF_LSB   = 8;
    localparam int ST_SLOT_LSB  = 12;

    // Mailbox push window covers ADDR_MBOX..ADDR_MBOX+3; the low two bits pick the target slot
    function automatic logic is_mbox_window(input logic [15:0] addr);
        return addr[15:2] == ADDR_MBOX[15:2];
    endfunction

endpackage

// File: rtl/j4io_mbox_fifo.sv
// Single inter-slot mailbox FIFO. A push while full drops the data and sets a
// sticky overflow flag; a flush empties the FIFO but leaves the overflow flag alone.
module j4io_mbox_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic             clr_ovf_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             empty_o,
    output logic             full_o,
    output logic             overflow_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             do_push, do_pop;

    assign empty_o    = (count_q == '0);
    assign full_o     = (count_q == (AW+1)'(DEPTH));
    assign overflow_o = ovf_q;
    assign data_o     = mem_q[rd_ptr_q];

    assign do_push = push_i & ~full_o  & ~flush_i;
    assign do_pop  = pop_i  & ~empty_o & ~flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointers are AW bits wide, so DEPTH being a power of two makes +1 wrap for free
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
        if (clr_ovf_i) ovf_d = 1'b0;
        if (push_i && full_o && !flush_i) ovf_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/j4_io_responder.sv
// IO responder for the 4-slot barrel-threaded j4 core: slot id, cycle counter,
// per-slot mailboxes and kill requests. Define J4IO_CYCLE_COUNTER_EN to build the counter.
module j4_io_responder
    import j4io_pkg::*;
#(
    parameter int MBOX_DEPTH = 4,
    parameter int WIDTH      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             io_rd,
    input  logic             io_wr,
    input  logic [15:0]      mem_addr,
    input  logic [WIDTH-1:0] dout,
    input  logic [1:0]       io_slot,
    output logic [WIDTH-1:0] io_din,
    output logic [3:0]       kill_slot_rq
);

    logic                 rd_only;
    logic                 kill_wr;
    logic [NUM_SLOTS-1:0] push_vec, pop_vec, flush_vec, clr_ovf_vec;
    logic [NUM_SLOTS-1:0] empty_vec, full_vec, ovf_vec;
    logic [WIDTH-1:0]     head [NUM_SLOTS];
    logic [15:0]          status_word;
    logic [15:0]          cycles_val;
    logic [WIDTH-1:0]     rd_data;
    logic [WIDTH-1:0]     io_din_q, io_din_d;
    logic [3:0]           kill_q, kill_d;

    // A simultaneous read+write is treated as a write only: no read side effects
    assign rd_only = io_rd & ~io_wr;
    assign kill_wr = io_wr & (mem_addr == ADDR_KILL);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_mbox
            assign push_vec[gi]    = io_wr & is_mbox_window(mem_addr) & (mem_addr[1:0] == 2'(gi));
            assign pop_vec[gi]     = rd_only & (mem_addr == ADDR_MBOX)   & (io_slot == 2'(gi));
            assign clr_ovf_vec[gi] = rd_only & (mem_addr == ADDR_STATUS) & (io_slot == 2'(gi));
            assign flush_vec[gi]   = kill_wr & dout[gi];

            j4io_mbox_fifo #(
                .DEPTH (MBOX_DEPTH),
                .WIDTH (WIDTH)
            ) u_fifo (
                .clk        (clk),
                .reset_i    (reset),
                .push_i     (push_vec[gi]),
                .pop_i      (pop_vec[gi]),
                .flush_i    (flush_vec[gi]),
                .clr_ovf_i  (clr_ovf_vec[gi]),
                .data_i     (dout),
                .data_o     (head[gi]),
                .empty_o    (empty_vec[gi]),
                .full_o     (full_vec[gi]),
                .overflow_o (ovf_vec[gi])
            );
        end
    endgenerate

`ifdef J4IO_CYCLE_COUNTER_EN
    logic [15:0] cycle_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cycle_q <= '0;
        else       cycle_q <= cycle_q + 16'd1;
    end

    assign cycles_val = cycle_q;
`else
    assign cycles_val = '0;
`endif

    // Status reflects pre-edge flags, so an overflow being cleared still reads as 1
    always_comb begin
        status_word = '0;
        status_word[ST_EMPTY_LSB +: NUM_SLOTS] = empty_vec;
        status_word[ST_FULL_LSB  +: NUM_SLOTS] = full_vec;
        status_word[ST_OVF_LSB   +: NUM_SLOTS] = ovf_vec;
        status_word[ST_SLOT_LSB  +: 2]         = io_slot;
    end

    always_comb begin
        rd_data = '0;
        case (mem_addr)
            ADDR_SLOTID: rd_data = WIDTH'(io_slot);
            ADDR_CYCLES: rd_data = WIDTH'(cycles_val);
            ADDR_MBOX:   rd_data = empty_vec[io_slot] ? '0 : head[io_slot];
            ADDR_STATUS: rd_data = WIDTH'(status_word);
            default:     rd_data = '0;
        endcase
    end

    always_comb begin
        io_din_d = io_din_q;
        if (io_rd && io_wr) io_din_d = '0;
        else if (io_rd)     io_din_d = rd_data;
        kill_d = kill_wr ? dout[3:0] : 4'b0000;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            io_din_q <= '0;
            kill_q   <= '0;
        end else begin
            io_din_q <= io_din_d;
            kill_q   <= kill_d;
        end
    end

    assign io_din       = io_din_q;
    assign kill_slot_rq = kill_q;

endmodule

// File: doc/j4_io_responder.md
Name: j4_io_responder

Overview:
- IO-side responder for the 4-slot barrel-threaded j4 core.
- Decodes the core's io_rd/io_wr strobes, address, write data and requesting slot.
- Returns io_din one register stage later. The core's internal 3-stage delay then aligns this data with the same slot's next turn, 4 cycles after the request.
- Provides a slot-ID register, a cycle counter, four per-slot inter-slot mailbox FIFOs, and a kill-request register driving the core's kill_slot_rq.

Parameters:
- MBOX_DEPTH, 4: entries per mailbox FIFO; power of two, 2..16.
- WIDTH, 16: data width; must match the core.

Ports:
- clk  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- io_rd  in  1  read strobe from core, valid in request cycle.
- io_wr  in  1  write strobe from core, valid in request cycle.
- mem_addr  in  16  IO address (core st0).
- dout  in  WIDTH  write data (core st1).
- io_slot  in  2  slot issuing the request.
- io_din  out  WIDTH  registered read data to core.
- kill_slot_rq  out  4  one-cycle kill pulses, one bit per slot.

Behaviour:
- Reset values: io_din=0, kill_slot_rq=0, all FIFOs empty, overflow flags 0, counter 0. Assertion of reset mid-operation discards pending pulses and FIFO contents.
- At most one request per cycle. All side effects and the io_din update occur on the clock edge ending the request cycle.
- io_din holds its value on cycles with no read.
- Read latency is exactly 1 edge. This is required: the core samples io_din during the cycle after the request.
- Address decode is an exact 16-bit compare:
  - 0x0001 R: io_din = {14'b0, io_slot}.
  - 0x0002 R: io_din = cycle counter; free-running, +1 every clk, wraps 0xFFFF->0.
  - 0x0010..0x0013 W: push dout into the mailbox of slot mem_addr[1:0].
  - 0x0010 R: pop the head of the requesting slot's own mailbox (io_slot) into io_din.
  - 0x0020 R: status word.
    - [3:0] empty[slot]; [7:4] full[slot]; [11:8] overflow[slot]; [13:12] io_slot; others 0.
    - Clears overflow[io_slot] only, on the same edge. The returned value shows the pre-clear flag.
  - 0x0040 W: kill_slot_rq <= dout[3:0] for exactly one cycle, then 0.
    - Mailboxes of the masked slots are flushed on the same edge.
    - A slot may kill itself.
  - Other addresses: writes ignored; reads return 0.
- Push to a full FIFO: data dropped, pointers unchanged, overflow[target] set (sticky).
- Pop of an empty FIFO: io_din=0, pointers unchanged.
- Push and pop of the same FIFO in one cycle cannot occur (single request per cycle).
- Pointers wrap modulo MBOX_DEPTH. Occupancy count has log2(MBOX_DEPTH)+1 bits.
- io_rd and io_wr both high (illegal): write performed, io_din <= 0, no pop.
- No state machine beyond the FIFOs: each access is a single-cycle transaction.

Optional Feature:
- Macro: J4IO_CYCLE_COUNTER_EN.
- Defined: the 16-bit cycle counter exists and 0x0002 returns it.
- Undefined: no counter flops; 0x0002 reads 0.

Decomposition:
- Package j4io_pkg:
  - address constants ADDR_SLOTID, ADDR_CYCLES, ADDR_MBOX, ADDR_STATUS, ADDR_KILL;
  - status bit-field offsets;
  - NUM_SLOTS=4.
- Sub-module j4io_mbox_fifo: single synchronous FIFO with push, pop, flush, empty, full and overflow outputs; instantiated NUM_SLOTS times.

Test Plan:
- Slot 2 reads 0x0001 -> io_din=0x0002 after 1 edge. The core's slot-2 result is 0x0002 four cycles after the request.
- Slot 0 writes 0x1234 to 0x0011, then slot 1 reads 0x0010 -> io_din=0x1234. A second read -> 0x0000. Status bit empty[1] returns to 1.
- Slot 3 writes 5 words (0xA0..0xA4) to 0x0012 with MBOX_DEPTH=4:
  - status shows full[2]=1, overflow[2]=1;
  - slot 2 pops 0xA0..0xA3 in order;
  - slot 2 status read clears overflow[2]; the next status read shows 0.
- Slot 1 writes 0x0005 to 0x0040 -> kill_slot_rq=4'b0101 for exactly one cycle, then 0. Mailboxes 0 and 2 read as empty.
- Assert reset while mailbox 1 holds 2 entries and a kill pulse is pending -> io_din=0, kill_slot_rq=0, all empty flags=1.
- With J4IO_CYCLE_COUNTER_EN: two 0x0002 reads 4 cycles apart differ by exactly 4, including across the 0xFFFF wrap. Without the macro: both read 0.
